pu_accum_ctrl: RTL and testbench
================================

Name: pu_accum_ctrl

Overview:
- Sequences the PU 4-input-channel adder tree (pu_adder4) across input-channel groups of a convolution job.
- Per output pixel: accepts cfg_grp_num beats of four PE partial sums, reduces each beat through the adder tree, accumulates the beats, then presents one result on a valid/ready output port.
- Sits between the PE array result registers and the PU post-processing stage (bias/activation/quantisation).

Parameters:
- PE_OUTPUT_WD, 18, width of each signed PE partial sum
- ACCUM_WD, 20, width of the signed adder-tree output
- OUT_WD, 26, width of the signed running accumulator and of acc_data_o
- GRP_CNT_WD, 6, width of the group-count config and counter
- OUT_CNT_WD, 12, width of the output-count config and counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_start_i  in  1  single-cycle job start pulse
- cfg_grp_num_i  in  GRP_CNT_WD  4-channel groups per output pixel
- cfg_out_num_i  in  OUT_CNT_WD  output pixels per job
- pe_vld_i  in  1  PE beat valid
- pe_rdy_o  out  1  PE beat ready
- pe_rf_ic1_i..pe_rf_ic4_i  in  PE_OUTPUT_WD each  signed partial sums
- acc_vld_o  out  1  result valid
- acc_rdy_i  in  1  result ready
- acc_data_o  out  OUT_WD  signed accumulated result
- acc_last_o  out  1  marks the last result of the job
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse at job end
- ovf_o  out  1  sticky signed-overflow flag for the current job

Behaviour:
- Reset: clk and rst are the only clock and reset. rst is asynchronous and active-high. On reset:
  - state=IDLE
  - pe_rdy_o=0, acc_vld_o=0, acc_last_o=0, busy_o=0, done_o=0, ovf_o=0
  - acc_data_o=0, all counters=0
- Reset mid-job aborts the job. No done_o pulse is issued.
- IDLE:
  - On cfg_start_i, latch cfg_grp_num_i and cfg_out_num_i, clear ovf_o and counters.
  - A cfg_grp_num_i of 0 is latched as 1.
  - If cfg_out_num_i==0, pulse done_o on the next cycle, stay IDLE, emit no output.
  - Otherwise go to ACCUM with busy_o=1.
- ACCUM:
  - pe_rdy_o=1, acc_vld_o=0.
  - A beat transfers when pe_vld_i and pe_rdy_o are both high.
  - beat_sum is the pu_adder4 output, sign-extended from ACCUM_WD to OUT_WD.
  - If grp_cnt==0, acc <= beat_sum. Otherwise acc <= acc + beat_sum.
  - Arithmetic is two's-complement wrap. On signed overflow of the add, set ovf_o; it stays set until the next cfg_start_i.
  - On the beat where grp_cnt==grp_num-1: grp_cnt <= 0 and go to OUTPUT. Otherwise grp_cnt increments.
  - Cycles with no transfer leave acc and grp_cnt unchanged.
- OUTPUT:
  - pe_rdy_o=0, acc_vld_o=1.
  - acc_data_o holds acc and acc_last_o=(out_cnt==out_num-1). Both stay stable until acc_rdy_i is seen.
  - On acc_vld_o and acc_rdy_i both high:
    - If last: go to IDLE, busy_o=0, done_o=1 for that next cycle.
    - Otherwise: out_cnt increments, go to ACCUM.
- Latency and throughput:
  - Final beat accepted at cycle T gives acc_vld_o=1 at T+1.
  - Peak throughput is one result per grp_num+1 cycles (one output bubble).
- cfg_start_i outside IDLE is ignored; config is not re-latched.
- pe_rf_ic*_i are sampled only on a transfer and may change freely otherwise.
- acc_rdy_i asserted before acc_vld_o has no effect.

Decomposition:
- Shared package pu_pkg holds:
  - PU state encoding (IDLE/ACCUM/OUTPUT)
  - default widths PE_OUTPUT_WD, ACCUM_WD, OUT_WD
- Single sub-module: pu_adder4 (existing), instantiated once for the per-beat reduction.
- Counters, FSM and accumulator stay in this module.

Test Plan:
- grp_num=3, out_num=1; beats (1,2,3,4), (10,10,10,10), (-5,0,0,0) with pe_vld_i continuous -> acc_data_o=45, acc_last_o=1 at T+1 after the third beat; done_o pulse one cycle after the handshake.
- grp_num=2, out_num=3; acc_rdy_i held low 4 cycles on the second result -> acc_data_o stable, pe_rdy_o=0 throughout; three results in order, acc_last_o only on the third.
- All PE inputs=-131072 (min 18-bit), grp_num=63 -> acc=-33030144 (fits 26 bits), ovf_o=0. Repeat with OUT_WD=24 -> ovf_o=1 and the result wraps.
- cfg_out_num_i=0 -> done_o one cycle later, acc_vld_o never asserted, busy_o stays 0. cfg_grp_num_i=0 -> behaves as grp_num=1.
- rst asserted in ACCUM after 2 of 4 beats -> all outputs 0 immediately. A new job (grp_num=1, beat 1,1,1,1) then yields 4.
- cfg_start_i pulsed mid-job with a different grp_num -> ignored; the current job completes with the original grp_num.

Source files
------------

// File: rtl/pu_pkg.sv
// Shared PU definitions: state encoding and default datapath widths.
// Imported by the PU accumulation control slice.
package pu_pkg;

  localparam int PE_OUTPUT_WD = 18;
  localparam int ACCUM_WD     = 20;
  localparam int OUT_WD       = 26;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

endpackage

// File: rtl/pu_adder4.sv
// PU 4-input-channel adder tree: sums four signed PE partial sums.
// Purely combinational so a beat is reduced in the cycle it transfers.
module pu_adder4
  import pu_pkg::*;
#(
  parameter int IN_WD  = PE_OUTPUT_WD,
  parameter int SUM_WD = ACCUM_WD
) (
  input  logic signed [IN_WD-1:0]  ic1_i,
  input  logic signed [IN_WD-1:0]  ic2_i,
  input  logic signed [IN_WD-1:0]  ic3_i,
  input  logic signed [IN_WD-1:0]  ic4_i,
  output logic signed [SUM_WD-1:0] sum_o
);

  localparam int EXT = SUM_WD - IN_WD;

  logic signed [SUM_WD-1:0] e1, e2, e3, e4;
  logic signed [SUM_WD-1:0] s12, s34;

  assign e1 = {{EXT{ic1_i[IN_WD-1]}}, ic1_i};
  assign e2 = {{EXT{ic2_i[IN_WD-1]}}, ic2_i};
  assign e3 = {{EXT{ic3_i[IN_WD-1]}}, ic3_i};
  assign e4 = {{EXT{ic4_i[IN_WD-1]}}, ic4_i};

  assign s12   = e1 + e2;
  assign s34   = e3 + e4;
  assign sum_o = s12 + s34;

endmodule

// File: rtl/pu_accum_ctrl.sv
// Sequences pu_adder4 over input-channel groups and accumulates
// one result per output pixel onto a valid/ready port.
module pu_accum_ctrl
  import pu_pkg::*;
#(
  parameter int PE_OUTPUT_WD = pu_pkg::PE_OUTPUT_WD,
  parameter int ACCUM_WD     = pu_pkg::ACCUM_WD,
  parameter int OUT_WD       = pu_pkg::OUT_WD,
  parameter int GRP_CNT_WD   = 6,
  parameter int OUT_CNT_WD   = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_start_i,
  input  logic [GRP_CNT_WD-1:0]          cfg_grp_num_i,
  input  logic [OUT_CNT_WD-1:0]          cfg_out_num_i,
  input  logic                           pe_vld_i,
  output logic                           pe_rdy_o,
  input  logic signed [PE_OUTPUT_WD-1:0] pe_rf_ic1_i,
  input  logic signed [PE_OUTPUT_WD-1:0] pe_rf_ic2_i,
  input  logic signed [PE_OUTPUT_WD-1:0] pe_rf_ic3_i,
  input  logic signed [PE_OUTPUT_WD-1:0] pe_rf_ic4_i,
  output logic                           acc_vld_o,
  input  logic                           acc_rdy_i,
  output logic signed [OUT_WD-1:0]       acc_data_o,
  output logic                           acc_last_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           ovf_o
);

  localparam int EXT = OUT_WD - ACCUM_WD;

  logic [1:0]               state;
  logic [GRP_CNT_WD-1:0]    grp_num;
  logic [GRP_CNT_WD-1:0]    grp_cnt;
  logic [OUT_CNT_WD-1:0]    out_num;
  logic [OUT_CNT_WD-1:0]    out_cnt;
  logic signed [OUT_WD-1:0] acc;
  logic signed [OUT_WD-1:0] beat_sum;
  logic signed [OUT_WD-1:0] add_res;
  logic signed [ACCUM_WD-1:0] tree_sum;
  logic                     done;
  logic                     ovf;
  logic                     xfer;
  logic                     out_hs;
  logic                     grp_end;
  logic                     out_end;
  logic                     add_ovf;
  logic                     start;

  pu_adder4 #(
    .IN_WD  (PE_OUTPUT_WD),
    .SUM_WD (ACCUM_WD)
  ) u_adder4 (
    .ic1_i (pe_rf_ic1_i),
    .ic2_i (pe_rf_ic2_i),
    .ic3_i (pe_rf_ic3_i),
    .ic4_i (pe_rf_ic4_i),
    .sum_o (tree_sum)
  );

  assign start   = (state == ST_IDLE) && cfg_start_i;
  assign xfer    = (state == ST_ACCUM) && pe_vld_i;
  assign out_hs  = (state == ST_OUTPUT) && acc_rdy_i;
  assign grp_end = grp_cnt == (grp_num - GRP_CNT_WD'(1));
  assign out_end = out_cnt == (out_num - OUT_CNT_WD'(1));

  assign beat_sum = {{EXT{tree_sum[ACCUM_WD-1]}}, tree_sum};
  assign add_res  = acc + beat_sum;
  assign add_ovf  = (acc[OUT_WD-1] == beat_sum[OUT_WD-1]) &&
                    (add_res[OUT_WD-1] != acc[OUT_WD-1]);

  // Job FSM, config latch and group/output counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      grp_num <= '0;
      out_num <= '0;
      grp_cnt <= '0;
      out_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_start_i) begin
            grp_num <= (cfg_grp_num_i == '0) ?
                       GRP_CNT_WD'(1) : cfg_grp_num_i;
            out_num <= cfg_out_num_i;
            grp_cnt <= '0;
            out_cnt <= '0;
            if (cfg_out_num_i == '0) begin
              done <= 1'b1;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (xfer) begin
            if (grp_end) begin
              grp_cnt <= '0;
              state   <= ST_OUTPUT;
            end else begin
              grp_cnt <= grp_cnt + GRP_CNT_WD'(1);
            end
          end
        end
        ST_OUTPUT: begin
          if (out_hs) begin
            if (out_end) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              out_cnt <= out_cnt + OUT_CNT_WD'(1);
              state   <= ST_ACCUM;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Running accumulator and sticky per-job overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (start) begin
      ovf <= 1'b0;
    end else if (xfer) begin
      if (grp_cnt == '0) begin
        acc <= beat_sum;
      end else begin
        acc <= add_res;
        if (add_ovf) ovf <= 1'b1;
      end
    end
  end

  assign pe_rdy_o   = (state == ST_ACCUM);
  assign acc_vld_o  = (state == ST_OUTPUT);
  assign acc_last_o = (state == ST_OUTPUT) && out_end;
  assign acc_data_o = acc;
  assign busy_o     = (state != ST_IDLE);
  assign done_o     = done;
  assign ovf_o      = ovf;

endmodule

// File: tb/tb_pu_accum_ctrl.sv
// Scoreboard bench for pu_accum_ctrl: a 26-bit and a 24-bit instance
// share stimulus; results are checked against an arithmetic model.
module tb_pu_accum_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_start_i = 1'b0;
  logic [5:0]  cfg_grp_num_i = '0;
  logic [11:0] cfg_out_num_i = '0;
  logic pe_vld_i = 1'b0;
  logic acc_rdy_i = 1'b0;
  logic signed [17:0] pe1 = '0, pe2 = '0, pe3 = '0, pe4 = '0;

  logic pe_rdy_o, acc_vld_o, acc_last_o, busy_o, done_o, ovf_o;
  logic signed [25:0] acc_data_o;
  logic b_pe_rdy, b_vld, b_last, b_busy, b_done, b_ovf;
  logic signed [23:0] b_data;

  pu_accum_ctrl u_dut (
    .clk(clk), .rst(rst),
    .cfg_start_i(cfg_start_i),
    .cfg_grp_num_i(cfg_grp_num_i),
    .cfg_out_num_i(cfg_out_num_i),
    .pe_vld_i(pe_vld_i), .pe_rdy_o(pe_rdy_o),
    .pe_rf_ic1_i(pe1), .pe_rf_ic2_i(pe2),
    .pe_rf_ic3_i(pe3), .pe_rf_ic4_i(pe4),
    .acc_vld_o(acc_vld_o), .acc_rdy_i(acc_rdy_i),
    .acc_data_o(acc_data_o), .acc_last_o(acc_last_o),
    .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o)
  );

  pu_accum_ctrl #(.OUT_WD(24)) u_dut24 (
    .clk(clk), .rst(rst),
    .cfg_start_i(cfg_start_i),
    .cfg_grp_num_i(cfg_grp_num_i),
    .cfg_out_num_i(cfg_out_num_i),
    .pe_vld_i(pe_vld_i), .pe_rdy_o(b_pe_rdy),
    .pe_rf_ic1_i(pe1), .pe_rf_ic2_i(pe2),
    .pe_rf_ic3_i(pe3), .pe_rf_ic4_i(pe4),
    .acc_vld_o(b_vld), .acc_rdy_i(acc_rdy_i),
    .acc_data_o(b_data), .acc_last_o(b_last),
    .busy_o(b_busy), .done_o(b_done), .ovf_o(b_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint d26;
    longint d24;
    bit     last;
    bit     o26;
    bit     o24;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int res_seen = 0;
  int stall = 0;
  int rdy_mode = 0;
  bit allow_done = 0;
  int dir_tbl[64][4];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint wrapw(input longint v, input int w);
    longint m = longint'(1) <<< w;
    longint r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic bit out_of_range(input longint v, input int w);
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -(longint'(1) <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

  function automatic int rnd_pe();
    case ($urandom_range(0, 3))
      0: return -131072;
      1: return 131071;
      2: return int'($urandom_range(0, 262143)) - 131072;
      default: return int'($urandom_range(0, 40)) - 20;
    endcase
  endfunction

  // ready driver: always, random, or a 4-cycle stall on result 1
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: acc_rdy_i = 1'b1;
        1: acc_rdy_i = ($urandom_range(0, 3) != 0);
        default: begin
          if (acc_vld_o && res_seen == 1 && stall < 4) begin
            acc_rdy_i = 1'b0;
            stall++;
          end else begin
            acc_rdy_i = 1'b1;
          end
        end
      endcase
    end
  end

  // monitor: pops the scoreboard on every result handshake
  initial begin
    bit hold = 0;
    bit dpend = 0;
    longint hd;
    bit hl;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0;
        dpend = 0;
      end else begin
        if (dpend) begin
          chk("done_pulse", done_o, 1);
          chk("busy_after_done", busy_o, 0);
          dpend = 0;
        end else if (done_o && !allow_done) begin
          chk("spurious_done", done_o, 0);
        end
        if (acc_vld_o) begin
          chk("pe_rdy_in_output", pe_rdy_o, 0);
          if (hold) begin
            chk("hold_data", acc_data_o, hd);
            chk("hold_last", acc_last_o, hl);
          end
          if (acc_rdy_i) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_result", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("data26", acc_data_o, e.d26);
              chk("last", acc_last_o, e.last);
              chk("ovf26", ovf_o, e.o26);
              chk("vld24", b_vld, 1);
              chk("data24", b_data, e.d24);
              chk("ovf24", b_ovf, e.o24);
              if (e.last) dpend = 1;
            end
            res_seen++;
            hold = 0;
          end else begin
            hold = 1;
            hd = acc_data_o;
            hl = acc_last_o;
          end
        end else begin
          hold = 0;
        end
      end
    end
  end

  task automatic send_beat(input int a, input int b, input int c,
                           input int d, input bit gap);
    bit got = 0;
    int k = 0;
    if (gap) begin
      repeat ($urandom_range(0, 2)) begin
        pe_vld_i = 1'b0;
        pe1 = 18'(rnd_pe());
        pe2 = 18'(rnd_pe());
        @(posedge clk); #1;
      end
    end
    pe_vld_i = 1'b1;
    pe1 = 18'(a); pe2 = 18'(b); pe3 = 18'(c); pe4 = 18'(d);
    while (!got && k < 500) begin
      @(negedge clk);
      got = pe_rdy_o;
      @(posedge clk); #1;
      k++;
    end
    if (!got) chk("beat_accept_timeout", 0, 1);
  endtask

  task automatic run_job(input int grp, input int outn, input int src,
                         input bit gap, input bit poke);
    int gn = (grp == 0) ? 1 : grp;
    bit j26 = 0;
    bit j24 = 0;
    int bt[64][4];
    bit got;
    res_seen = 0;
    stall = 0;
    if (outn == 0) allow_done = 1;
    cfg_grp_num_i = 6'(grp);
    cfg_out_num_i = 12'(outn);
    cfg_start_i = 1'b1;
    @(posedge clk); #1;
    cfg_start_i = 1'b0;
    if (outn == 0) begin
      @(negedge clk);
      chk("zero_job_done", done_o, 1);
      chk("zero_job_busy", busy_o, 0);
      chk("zero_job_vld", acc_vld_o, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("zero_job_done_once", done_o, 0);
      chk("zero_job_vld2", acc_vld_o, 0);
      allow_done = 0;
      return;
    end
    for (int p = 0; p < outn; p++) begin
      exp_t e;
      longint a26 = 0;
      longint a24 = 0;
      for (int g = 0; g < gn; g++) begin
        longint s = 0;
        for (int i = 0; i < 4; i++) begin
          case (src)
            0: bt[g][i] = rnd_pe();
            1: bt[g][i] = dir_tbl[g][i];
            default: bt[g][i] = -131072;
          endcase
          s += bt[g][i];
        end
        if (g == 0) begin
          a26 = s;
          a24 = s;
        end else begin
          if (out_of_range(a26 + s, 26)) j26 = 1;
          if (out_of_range(a24 + s, 24)) j24 = 1;
          a26 = wrapw(a26 + s, 26);
          a24 = wrapw(a24 + s, 24);
        end
      end
      e.d26 = a26;
      e.d24 = a24;
      e.last = (p == outn - 1);
      e.o26 = j26;
      e.o24 = j24;
      exp_q.push_back(e);
      for (int g = 0; g < gn; g++) begin
        send_beat(bt[g][0], bt[g][1], bt[g][2], bt[g][3], gap);
        if (poke && p == 0 && g == 0 && gn > 1) begin
          pe_vld_i = 1'b0;
          cfg_grp_num_i = 6'(gn + 3);
          cfg_start_i = 1'b1;
          @(posedge clk); #1;
          cfg_start_i = 1'b0;
        end
      end
      pe_vld_i = 1'b0;
      @(negedge clk);
      chk("latency_vld", acc_vld_o, 1);
      @(posedge clk); #1;
    end
    got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      got = done_o;
    end
    chk("job_done_seen", got, 1);
    @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("busy_idle", busy_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nj;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pe_rdy", pe_rdy_o, 0);
    chk("rst_vld", acc_vld_o, 0);
    chk("rst_last", acc_last_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_data", acc_data_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    dir_tbl[0] = '{1, 2, 3, 4};
    dir_tbl[1] = '{10, 10, 10, 10};
    dir_tbl[2] = '{-5, 0, 0, 0};
    rdy_mode = 0;
    run_job(3, 1, 1, 0, 0);

    rdy_mode = 2;
    run_job(2, 3, 0, 0, 0);

    rdy_mode = 0;
    run_job(63, 1, 2, 0, 0);

    run_job(5, 0, 0, 0, 0);
    run_job(0, 2, 0, 1, 0);

    run_job(4, 1, 0, 0, 0);
    run_job(2, 2, 0, 0, 1);

    exp_q.delete();
    cfg_grp_num_i = 6'd4;
    cfg_out_num_i = 12'd1;
    cfg_start_i = 1'b1;
    @(posedge clk); #1;
    cfg_start_i = 1'b0;
    send_beat(100, 200, 300, 400, 0);
    send_beat(5, 6, 7, 8, 0);
    pe_vld_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("abort_pe_rdy", pe_rdy_o, 0);
    chk("abort_vld", acc_vld_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_data", acc_data_o, 0);
    chk("abort_busy24", b_busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dir_tbl[0] = '{1, 1, 1, 1};
    run_job(1, 1, 1, 0, 0);

    rdy_mode = 1;
    for (int j = 0; j < 10; j++) begin
      nj = $urandom_range(0, 9);
      run_job((nj == 0) ? 63 : int'($urandom_range(0, 12)),
              int'($urandom_range(0, 4)), 0, 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
